// File: rtl/ping_pong_pkg.sv
// Shared constants for the ping-pong counter display: segment patterns and
// the digit-slot encoding used by the scan multiplexer.
package ping_pong_pkg;

  typedef enum logic [1:0] {
    DIG_GLYPH0 = 2'd0,
    DIG_GLYPH1 = 2'd1,
    DIG_ONES   = 2'd2,
    DIG_TENS   = 2'd3
  } digit_idx_e;

  // Segment order is {g,f,e,d,c,b,a}, active low.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_UP    = 7'b1011100;
  localparam logic [6:0] SEG_DOWN  = 7'b1100011;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  // Any BCD code above 9 decodes to a dark digit.
  localparam logic [3:0] BCD_BLANK = 4'hF;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder; codes above 9 are dark.
module seg7_decode
  import ping_pong_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (bcd <= 4'd9) begin
      seg = SEG_DIGIT[bcd];
    end
  end

endmodule

// File: rtl/ping_pong_seg7_display.sv
// Four-digit multiplexed common-anode display for the ping-pong counter:
// tens, ones and a two-digit direction glyph, with inputs frozen per frame.
module ping_pong_seg7_display
  import ping_pong_pkg::*;
#(
  parameter int SCAN_DIV_W         = 17,
  parameter bit BLANK_LEADING_ZERO = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] value,
  input  logic       direction,
  input  logic       blank,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  logic [SCAN_DIV_W-1:0] div;
  logic                  tick;
  digit_idx_e            idx;
  logic [3:0]            snap_val;
  logic                  snap_dir;
  logic                  tens;
  logic [3:0]            ones;
  logic [3:0]            digit_bcd;
  logic [6:0]            digit_seg;
  logic [6:0]            seg_next;
  logic [3:0]            an_next;

  assign tick = &div;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      idx <= DIG_GLYPH0;
    end else begin
      div <= div + SCAN_DIV_W'(1);
      if (tick) begin
        idx <= digit_idx_e'(idx + 2'd1);
      end
    end
  end

  // Inputs are captured only as the last digit of a frame retires, so a
  // whole frame is always drawn from one consistent value/direction pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_val <= 4'd0;
      snap_dir <= 1'b1;
    end else if (tick && idx == DIG_TENS) begin
      snap_val <= value;
      snap_dir <= direction;
    end
  end

  assign tens = (snap_val >= 4'd10);
  assign ones = tens ? (snap_val - 4'd10) : snap_val;

  // A suppressed leading zero is routed through the decoder as an
  // out-of-range code so there is a single decoder on the muxed digit.
  always_comb begin
    digit_bcd = BCD_BLANK;
    unique case (idx)
      DIG_TENS: digit_bcd = (!tens && BLANK_LEADING_ZERO) ? BCD_BLANK : {3'b000, tens};
      DIG_ONES: digit_bcd = ones;
      default:  digit_bcd = BCD_BLANK;
    endcase
  end

  seg7_decode u_decode (
    .bcd (digit_bcd),
    .seg (digit_seg)
  );

  always_comb begin
    seg_next = digit_seg;
    if (idx == DIG_GLYPH0 || idx == DIG_GLYPH1) begin
      seg_next = snap_dir ? SEG_UP : SEG_DOWN;
    end
    an_next = ~(4'b0001 << idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
    end else if (blank) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
    end else begin
      an  <= an_next;
      seg <= seg_next;
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_ping_pong_seg7_display.sv
// Scoreboard bench for ping_pong_seg7_display with a fast scan divider; two
// instances cover both leading-zero settings from the same stimulus.
module tb_ping_pong_seg7_display;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic [6:0] seg_nb;
    int         gap;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] value = 4'd3;
  logic       direction = 1'b0;
  logic       blank = 1'b0;
  logic [3:0] an, an_nb;
  logic [6:0] seg, seg_nb;
  logic       dp, dp_nb;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ping_pong_seg7_display #(.SCAN_DIV_W(2), .BLANK_LEADING_ZERO(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .value     (value),
    .direction (direction),
    .blank     (blank),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  ping_pong_seg7_display #(.SCAN_DIV_W(2), .BLANK_LEADING_ZERO(1'b0)) dut_nb (
    .clk       (clk),
    .rst_n     (rst_n),
    .value     (value),
    .direction (direction),
    .blank     (blank),
    .an        (an_nb),
    .seg       (seg_nb),
    .dp        (dp_nb)
  );

  function automatic logic [6:0] digitCode(input int d);
    case (d)
      0:       return 7'b1000000;
      1:       return 7'b1111001;
      2:       return 7'b0100100;
      3:       return 7'b0110000;
      4:       return 7'b0011001;
      5:       return 7'b0010010;
      6:       return 7'b0000010;
      7:       return 7'b1111000;
      8:       return 7'b0000000;
      9:       return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 'b%0b expected 'b%0b", tag, observed, expected);
    end
  endtask

  task automatic pushDigit(input logic [3:0] a, input logic [6:0] s, input logic [6:0] s_nb,
                           input int gap, input string name);
    exp_t e;
    e.an     = a;
    e.seg    = s;
    e.seg_nb = s_nb;
    e.gap    = gap;
    e.name   = name;
    exp_q.push_back(e);
  endtask

  // Expected frame, in scan order, for a given snapshot of value/direction.
  task automatic pushFrame(input int v, input logic d, input int first_gap);
    logic [6:0] glyph;
    int t;
    int o;
    glyph = d ? 7'b1011100 : 7'b1100011;
    t = v / 10;
    o = v % 10;
    pushDigit(4'b1110, glyph, glyph, first_gap, $sformatf("v%0d glyph0", v));
    pushDigit(4'b1101, glyph, glyph, 4, $sformatf("v%0d glyph1", v));
    pushDigit(4'b1011, digitCode(o), digitCode(o), 4, $sformatf("v%0d ones", v));
    pushDigit(4'b0111, (t == 0) ? 7'h7F : digitCode(t), digitCode(t), 4, $sformatf("v%0d tens", v));
  endtask

  task automatic applyStimulus(input int v, input logic d, input int first_gap);
    value     = 4'(v);
    direction = d;
    pushFrame(v, d, first_gap);
  endtask

  // Pops n expectations, each waiting (bounded) for its anode pattern.
  task automatic checkDigits(input int n);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      int waited;
      e = exp_q.pop_front();
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (an !== e.an && waited < 20);
      checkOutput({e.name, " an"}, int'(an), int'(e.an));
      checkOutput({e.name, " gap"}, waited, e.gap);
      checkOutput({e.name, " seg"}, int'(seg), int'(e.seg));
      checkOutput({e.name, " an_nb"}, int'(an_nb), int'(e.an));
      checkOutput({e.name, " seg_nb"}, int'(seg_nb), int'(e.seg_nb));
      checkOutput({e.name, " dp"}, int'(dp), 1);
    end
  endtask

  initial begin
    $display("[TB] start");

    repeat (3) @(negedge clk);
    checkOutput("reset an", int'(an), 'b1111);
    checkOutput("reset seg", int'(seg), 'h7F);
    checkOutput("reset dp", int'(dp), 1);
    checkOutput("reset an_nb", int'(an_nb), 'b1111);

    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("pre-reset an", int'(an), 'b1101);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset an", int'(an), 'b1111);
    checkOutput("async reset seg", int'(seg), 'h7F);
    checkOutput("async reset seg_nb", int'(seg_nb), 'h7F);

    // Inputs held at 3/down through reset: first frame must still show 0/up.
    @(negedge clk);
    rst_n = 1'b1;
    pushFrame(0, 1'b1, 1);
    checkDigits(4);

    applyStimulus(13, 1'b1, 4);
    checkDigits(4);

    applyStimulus(7, 1'b1, 4);
    checkDigits(4);

    applyStimulus(5, 1'b1, 4);
    checkDigits(2);
    applyStimulus(9, 1'b1, 4);
    checkDigits(6);

    applyStimulus(9, 1'b0, 4);
    checkDigits(4);

    applyStimulus(15, 1'b0, 4);
    checkDigits(2);
    blank = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput($sformatf("blank an %0d", i), int'(an), 'b1111);
      checkOutput($sformatf("blank seg %0d", i), int'(seg), 'h7F);
    end
    blank = 1'b0;
    // The ones slot fell entirely inside the blank window; scanning moved on
    // to the tens slot, which appears on the first edge after release.
    void'(exp_q.pop_front());
    exp_q[0].gap = 1;
    checkDigits(1);
    applyStimulus(15, 1'b0, 1);
    checkDigits(4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
